// File: rtl/axil_selftest_pkg.sv
// Shared types for the AXI4-Lite BRAM self-test: FSM states, AXI response codes
// and the generated test-pattern function.
package axil_selftest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_WR_GAP,
        ST_RD_GAP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Computed at 64 bits; callers truncate to their data width, which keeps it mod 2^DATA_W.
    function automatic logic [63:0] pattern_word(input logic [63:0] seed,
                                                 input logic [63:0] step,
                                                 input logic [31:0] idx);
        return seed + step * {32'd0, idx};
    endfunction

endpackage

// File: rtl/axil_bram_selftest.sv
// AXI4-Lite write-then-read-back self-test master; one transaction in flight, waits on every handshake.
// AXIL_SELFTEST_RESP_CHECK_EN: also count BRESP/RRESP != OKAY as errors.
module axil_bram_selftest
    import axil_selftest_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter int              DATA_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'hA000_0000),
    parameter int              NUM_WORDS    = 16,
    parameter logic [31:0]     PATTERN_SEED = 32'h0123_4567,
    parameter logic [31:0]     PATTERN_STEP = 32'h89AB_CDEF,
    parameter int              GAP_CYCLES   = 2,
    localparam int             CW           = $clog2(2*NUM_WORDS+1)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CW-1:0]       err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   m_axil_awaddr,
    output logic [2:0]          m_axil_awprot,
    output logic                m_axil_awvalid,
    input  logic                m_axil_awready,
    output logic [DATA_W-1:0]   m_axil_wdata,
    output logic [DATA_W/8-1:0] m_axil_wstrb,
    output logic                m_axil_wvalid,
    input  logic                m_axil_wready,
    input  logic [1:0]          m_axil_bresp,
    input  logic                m_axil_bvalid,
    output logic                m_axil_bready,
    output logic [ADDR_W-1:0]   m_axil_araddr,
    output logic [2:0]          m_axil_arprot,
    output logic                m_axil_arvalid,
    input  logic                m_axil_arready,
    input  logic [DATA_W-1:0]   m_axil_rdata,
    input  logic [1:0]          m_axil_rresp,
    input  logic                m_axil_rvalid,
    output logic                m_axil_rready
);

    localparam int IW = $clog2(NUM_WORDS+1);
    localparam int GW = $clog2(GAP_CYCLES+2);

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]       err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;

    logic                go_wr, go_rd, launch_wr, launch_rd, err_hit, rd_bad;
    logic [ADDR_W-1:0]   err_addr;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [IW-1:0] i);
        return BASE_ADDR + ADDR_W'(i) * ADDR_W'(DATA_W/8);
    endfunction

    function automatic logic [DATA_W-1:0] word_data(input logic [IW-1:0] i);
        return DATA_W'(pattern_word(64'(PATTERN_SEED), 64'(PATTERN_STEP), 32'(i)));
    endfunction

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        gap_d            = gap_q;
        awvalid_d        = awvalid_q;
        wvalid_d         = wvalid_q;
        arvalid_d        = arvalid_q;
        awaddr_d         = awaddr_q;
        wdata_d          = wdata_q;
        araddr_d         = araddr_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        go_wr            = 1'b0;
        go_rd            = 1'b0;
        launch_wr        = 1'b0;
        launch_rd        = 1'b0;
        err_hit          = 1'b0;
        rd_bad           = 1'b0;
        err_addr         = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d            = '0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    launch_wr        = 1'b1;
                end
            end
            ST_WR_REQ: begin
                awvalid_d = awvalid_q && !m_axil_awready;
                wvalid_d  = wvalid_q && !m_axil_wready;
                if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axil_bvalid) begin
`ifdef AXIL_SELFTEST_RESP_CHECK_EN
                    if (m_axil_bresp != RESP_OKAY) begin
                        err_hit  = 1'b1;
                        err_addr = awaddr_q;
                    end
`endif
                    if (idx_q == IW'(NUM_WORDS-1)) begin
                        idx_d = '0;
                        go_rd = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        go_wr = 1'b1;
                    end
                end
            end
            ST_WR_GAP, ST_RD_GAP: begin
                if (gap_q == GW'(GAP_CYCLES-1)) begin
                    launch_wr = (state_q == ST_WR_GAP);
                    launch_rd = (state_q == ST_RD_GAP);
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_RD_REQ: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axil_rvalid) begin
                    rd_bad = (m_axil_rdata != word_data(idx_q));
`ifdef AXIL_SELFTEST_RESP_CHECK_EN
                    rd_bad = rd_bad || (m_axil_rresp != RESP_OKAY);
`endif
                    if (rd_bad) begin
                        err_hit  = 1'b1;
                        err_addr = araddr_q;
                    end
                    if (idx_q == IW'(NUM_WORDS-1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        go_rd = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // With no gap the next request is launched straight from the response state.
        if (go_wr || go_rd) begin
            if (GAP_CYCLES == 0) begin
                launch_wr = go_wr;
                launch_rd = go_rd;
            end else begin
                state_d = go_wr ? ST_WR_GAP : ST_RD_GAP;
                gap_d   = '0;
            end
        end

        if (err_hit) begin
            err_count_d = err_count_q + CW'(1);
            if (err_count_q == '0) begin
                first_err_addr_d = err_addr;
            end
        end

        if (launch_wr) begin
            state_d   = ST_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = word_addr(idx_d);
            wdata_d   = word_data(idx_d);
        end
        if (launch_rd) begin
            state_d   = ST_RD_REQ;
            arvalid_d = 1'b1;
            araddr_d  = word_addr(idx_d);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            gap_q            <= '0;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            awaddr_q         <= '0;
            wdata_q          <= '0;
            araddr_q         <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            gap_q            <= gap_d;
            awvalid_q        <= awvalid_d;
            wvalid_q         <= wvalid_d;
            arvalid_q        <= arvalid_d;
            awaddr_q         <= awaddr_d;
            wdata_q          <= wdata_d;
            araddr_q         <= araddr_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

`ifndef AXIL_SELFTEST_RESP_CHECK_EN
    logic unused_resp;
    assign unused_resp = ^{m_axil_bresp, m_axil_rresp};
`endif

    assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_count_q == '0);
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = (state_q == ST_WR_RESP);
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_axil_bram_selftest.sv
// Self-checking bench: behavioural BRAM slave with random/fixed latencies and fault injection.
`timescale 1ns/1ps
module tb_axil_bram_selftest;
    import axil_selftest_pkg::*;

    localparam int          NW   = 4;
    localparam int          CW   = $clog2(2*NW+1);
    localparam logic [31:0] BASE = 32'hA000_0000;
    localparam logic [31:0] SEED = 32'h0123_4567;
    localparam logic [31:0] STEP = 32'h89AB_CDEF;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [CW-1:0] err_count;
    logic [31:0] first_err_addr;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready;
    logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_arready = 1'b0;
    logic        m_axil_bvalid = 1'b0, m_axil_rvalid = 1'b0;
    logic [1:0]  m_axil_bresp = 2'b00, m_axil_rresp = 2'b00;
    logic [31:0] m_axil_rdata = 32'd0;

    axil_bram_selftest #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .NUM_WORDS(NW),
        .PATTERN_SEED(SEED), .PATTERN_STEP(STEP), .GAP_CYCLES(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_fail = 0;

    // slave configuration (-1 = random latency 0..3)
    int          aw_cfg = -1, w_cfg = -1, b_cfg = -1, ar_cfg = -1, r_cfg = -1;
    logic [15:0] corrupt_mask = 16'd0;
    logic [15:0] bresp_err_mask = 16'd0;

    logic [31:0] mem [16];
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          got_aw, got_w, b_pend, r_pend, b_is_err;
    logic [31:0] lat_aw_addr, lat_w_data, r_addr;
    logic        p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] rd_addr_log[$];
    int          proto_err = 0, overlap_err = 0;
    bit          saw_w_drop = 0;
    logic        last_r_done = 1'b0, last_r_busy = 1'b1;

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) & 15;
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        return SEED + STEP * 32'(i);
    endfunction

    function automatic logic [31:0] exp_addr(input int i);
        return BASE + 32'(4 * i);
    endfunction

    task automatic slave_clear();
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_rvalid = 0; m_axil_bresp = RESP_OKAY; m_axil_rresp = RESP_OKAY;
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        aw_wait = pick(aw_cfg); w_wait = pick(w_cfg); ar_wait = pick(ar_cfg);
    endtask

    // Slave: at each falling edge, account for the handshakes of the rising edge just passed,
    // then decide the ready/valid levels for the next rising edge.
    initial begin : slave
        bit hs_aw, hs_w, hs_ar;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                slave_clear();
            end else begin
                hs_aw = m_axil_awready && p_awvalid;
                hs_w  = m_axil_wready && p_wvalid;
                hs_ar = m_axil_arready && p_arvalid;
                if (hs_aw) begin got_aw = 1; lat_aw_addr = p_awaddr; m_axil_awready = 0; aw_wait = pick(aw_cfg); end
                if (hs_w)  begin got_w = 1; lat_w_data = p_wdata; m_axil_wready = 0; w_wait = pick(w_cfg); end
                if (m_axil_bvalid && p_bready) begin m_axil_bvalid = 0; b_pend = 0; end
                if (hs_ar) begin
                    r_addr = p_araddr; r_pend = 1; r_wait = pick(r_cfg);
                    rd_addr_log.push_back(p_araddr);
                    m_axil_arready = 0; ar_wait = pick(ar_cfg);
                end
                if (m_axil_rvalid && p_rready) begin
                    m_axil_rvalid = 0; r_pend = 0;
                    last_r_done = done; last_r_busy = busy;
                end
                if (got_aw && got_w) begin
                    mem[widx(lat_aw_addr)] = lat_w_data;
                    wr_addr_log.push_back(lat_aw_addr);
                    wr_data_log.push_back(lat_w_data);
                    got_aw = 0; got_w = 0;
                    b_pend = 1; b_wait = pick(b_cfg);
                    b_is_err = bresp_err_mask[widx(lat_aw_addr)];
                end
                if (p_awvalid && !hs_aw && (!m_axil_awvalid || m_axil_awaddr !== p_awaddr)) proto_err++;
                if (p_wvalid && !hs_w && (!m_axil_wvalid || m_axil_wdata !== p_wdata)) proto_err++;
                if (p_arvalid && !hs_ar && (!m_axil_arvalid || m_axil_araddr !== p_araddr)) proto_err++;
                if ((m_axil_awvalid || m_axil_wvalid || m_axil_arvalid) && (b_pend || r_pend)) overlap_err++;
                if (m_axil_awvalid && !m_axil_wvalid) saw_w_drop = 1;
                if (b_pend && !m_axil_bvalid) begin
                    if (b_wait == 0) begin
                        m_axil_bvalid = 1;
                        m_axil_bresp  = b_is_err ? RESP_SLVERR : RESP_OKAY;
                    end else b_wait--;
                end
                if (r_pend && !m_axil_rvalid) begin
                    if (r_wait == 0) begin
                        m_axil_rvalid = 1;
                        m_axil_rresp  = RESP_OKAY;
                        m_axil_rdata  = mem[widx(r_addr)] ^ {31'd0, corrupt_mask[widx(r_addr)]};
                    end else r_wait--;
                end
                if (m_axil_awvalid && !got_aw && !m_axil_awready) begin
                    if (aw_wait == 0) m_axil_awready = 1; else aw_wait--;
                end
                if (m_axil_wvalid && !got_w && !m_axil_wready) begin
                    if (w_wait == 0) m_axil_wready = 1; else w_wait--;
                end
                if (m_axil_arvalid && !m_axil_arready) begin
                    if (ar_wait == 0) m_axil_arready = 1; else ar_wait--;
                end
                p_awvalid = m_axil_awvalid; p_wvalid = m_axil_wvalid; p_arvalid = m_axil_arvalid;
                p_bready = m_axil_bready; p_rready = m_axil_rready;
                p_awaddr = m_axil_awaddr; p_wdata = m_axil_wdata; p_araddr = m_axil_araddr;
            end
        end
    end

    // Pulse start for one cycle and wait (bounded) for done.
    task automatic do_run(output bit ok, output bit lat_ok);
        wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
        @(negedge aclk); start = 1;
        @(posedge aclk); #1;
        lat_ok = busy && m_axil_awvalid && m_axil_wvalid;
        @(negedge aclk); start = 0;
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge aclk);
            ok = done;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        n_cmp++;
        if ({busy, done, pass, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready} !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000",
                {busy, done, pass, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready});
        end
        n_cmp++;
        if ({err_count, first_err_addr, m_axil_awaddr, m_axil_wdata, m_axil_araddr} !== '0) begin
            n_fail++; $display("FAIL reset_data: err=%0d first=%h aw=%h w=%h ar=%h expected all 0",
                err_count, first_err_addr, m_axil_awaddr, m_axil_wdata, m_axil_araddr);
        end
        aresetn = 1;
        @(posedge aclk); #1;
        n_cmp++;
        if ({m_axil_awprot, m_axil_arprot, m_axil_wstrb, busy, done} !== {3'd0, 3'd0, 4'hF, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_idle: awprot=%b arprot=%b wstrb=%b busy=%b done=%b expected 000 000 1111 0 0",
                m_axil_awprot, m_axil_arprot, m_axil_wstrb, busy, done);
        end
    endtask

    task automatic test_basic();
        bit ok, lat_ok;
        aw_cfg = -1; w_cfg = -1; b_cfg = -1; ar_cfg = -1; r_cfg = -1;
        corrupt_mask = 0; bresp_err_mask = 0; proto_err = 0; overlap_err = 0;
        do_run(ok, lat_ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: done=%b expected 1", done); end
        n_cmp++;
        if (!lat_ok) begin n_fail++; $display("FAIL start_latency: busy/awvalid/wvalid not all 1 the cycle after start"); end
        n_cmp++;
        if (wr_addr_log.size() != NW || rd_addr_log.size() != NW) begin
            n_fail++; $display("FAIL basic_count: writes=%0d reads=%0d expected %0d", wr_addr_log.size(), rd_addr_log.size(), NW);
        end else begin
            for (int i = 0; i < NW; i++) begin
                n_cmp++;
                if (wr_addr_log[i] !== exp_addr(i) || wr_data_log[i] !== exp_data(i) || rd_addr_log[i] !== exp_addr(i)) begin
                    n_fail++; $display("FAIL basic_word%0d: wa=%h wd=%h ra=%h expected %h %h %h", i,
                        wr_addr_log[i], wr_data_log[i], rd_addr_log[i], exp_addr(i), exp_data(i), exp_addr(i));
                end
            end
        end
        n_cmp++;
        if ({pass, err_count, first_err_addr} !== {1'b1, CW'(0), 32'd0}) begin
            n_fail++; $display("FAIL basic_result: pass=%b err=%0d first=%h expected 1 0 0", pass, err_count, first_err_addr);
        end
        n_cmp++;
        if ({last_r_done, last_r_busy} !== 2'b10) begin
            n_fail++; $display("FAIL done_timing: done=%b busy=%b after last R, expected 1 0", last_r_done, last_r_busy);
        end
        n_cmp++;
        if (proto_err != 0 || overlap_err != 0) begin
            n_fail++; $display("FAIL protocol: unstable=%0d overlapping=%0d expected 0 0", proto_err, overlap_err);
        end
    endtask

    task automatic test_corrupt();
        bit ok, lat_ok;
        int exp_err;
        logic [31:0] exp_first;
        for (int t = 0; t < 4; t++) begin
            corrupt_mask = (t == 0) ? 16'h0004 : 16'($urandom_range(0, 15));
            exp_err = 0; exp_first = 0;
            for (int i = 0; i < NW; i++) begin
                if (corrupt_mask[i]) begin
                    if (exp_err == 0) exp_first = exp_addr(i);
                    exp_err++;
                end
            end
            do_run(ok, lat_ok);
            n_cmp++;
            if (!ok || pass !== (exp_err == 0) || err_count !== CW'(exp_err) || first_err_addr !== exp_first) begin
                n_fail++; $display("FAIL corrupt_%0d: mask=%h done=%b pass=%b err=%0d first=%h expected pass=%0d err=%0d first=%h",
                    t, corrupt_mask, ok, pass, err_count, first_err_addr, exp_err == 0, exp_err, exp_first);
            end
        end
        corrupt_mask = 0;
    endtask

    task automatic test_aw_delay();
        bit ok, lat_ok;
        aw_cfg = 5; w_cfg = 1; b_cfg = 0; ar_cfg = 0; r_cfg = 0;
        saw_w_drop = 0; proto_err = 0;
        do_run(ok, lat_ok);
        n_cmp++;
        if (!ok || !saw_w_drop || proto_err != 0) begin
            n_fail++; $display("FAIL aw_delay_drop: done=%b w_dropped_aw_high=%b unstable=%0d expected 1 1 0", ok, saw_w_drop, proto_err);
        end
        n_cmp++;
        if (wr_addr_log.size() != NW || pass !== 1'b1) begin
            n_fail++; $display("FAIL aw_delay_writes: writes=%0d pass=%b expected %0d 1", wr_addr_log.size(), pass, NW);
        end
        aw_cfg = -1; w_cfg = -1; b_cfg = -1; ar_cfg = -1; r_cfg = -1;
    endtask

    task automatic test_bresp();
        bit ok, lat_ok;
        int exp_err;
        logic [31:0] exp_first;
`ifdef AXIL_SELFTEST_RESP_CHECK_EN
        exp_err = 1; exp_first = exp_addr(1);
`else
        exp_err = 0; exp_first = 0;
`endif
        bresp_err_mask = 16'h0002;
        do_run(ok, lat_ok);
        n_cmp++;
        if (!ok || err_count !== CW'(exp_err) || first_err_addr !== exp_first || pass !== (exp_err == 0)) begin
            n_fail++; $display("FAIL bresp: done=%b pass=%b err=%0d first=%h expected err=%0d first=%h",
                ok, pass, err_count, first_err_addr, exp_err, exp_first);
        end
        bresp_err_mask = 0;
    endtask

    task automatic test_start_held();
        bit ok;
        wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
        corrupt_mask = 16'h0004;
        @(negedge aclk); start = 1;
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin @(negedge aclk); ok = done; end
        n_cmp++;
        if (!ok || wr_addr_log.size() != NW || err_count !== CW'(1)) begin
            n_fail++; $display("FAIL held_first_run: done=%b writes=%0d err=%0d expected 1 %0d 1", ok, wr_addr_log.size(), err_count, NW);
        end
        corrupt_mask = 0;
        @(posedge aclk); #1;
        n_cmp++;
        if ({done, busy, err_count, first_err_addr} !== {1'b0, 1'b1, CW'(0), 32'd0}) begin
            n_fail++; $display("FAIL held_restart: done=%b busy=%b err=%0d first=%h expected 0 1 0 0", done, busy, err_count, first_err_addr);
        end
        @(negedge aclk); start = 0;
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin @(negedge aclk); ok = done; end
        n_cmp++;
        if (!ok || pass !== 1'b1 || wr_addr_log.size() != 2 * NW) begin
            n_fail++; $display("FAIL held_second_run: done=%b pass=%b writes=%0d expected 1 1 %0d", ok, pass, wr_addr_log.size(), 2 * NW);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, lat_ok, found;
        r_cfg = 8;
        @(negedge aclk); start = 1;
        @(negedge aclk); start = 0;
        found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin @(negedge aclk); found = m_axil_rready; end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL reset_mid_reach: rready=%b expected 1 before timeout", m_axil_rready); end
        #2 aresetn = 0;
        #1;
        n_cmp++;
        if ({busy, done, pass, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready} !== 8'd0
            || err_count !== CW'(0) || m_axil_araddr !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_async: ctrl=%b err=%0d araddr=%h expected 0 0 0",
                {busy, done, pass, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready}, err_count, m_axil_araddr);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1;
        repeat (3) @(posedge aclk);
        #1;
        n_cmp++;
        if ({busy, done, m_axil_awvalid, m_axil_arvalid} !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid_idle: busy=%b done=%b awvalid=%b arvalid=%b expected 0 0 0 0", busy, done, m_axil_awvalid, m_axil_arvalid);
        end
        r_cfg = -1;
        do_run(ok, lat_ok);
        n_cmp++;
        if (!ok || pass !== 1'b1 || wr_addr_log.size() != NW) begin
            n_fail++; $display("FAIL reset_mid_rerun: done=%b pass=%b writes=%0d expected 1 1 %0d", ok, pass, wr_addr_log.size(), NW);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corrupt();
        test_aw_delay();
        test_bresp();
        test_start_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
